// File: rtl/id_regfile_stage_pkg.sv
// Shared defaults and a constant clog2 helper for the decode-stage register file.
package id_regfile_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREG_DEF   = 32;

  // Smallest r with 2**r >= n; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/id_regfile_stage_reg_bank.sv
// Register array with one write port and two write-first bypassed read ports.
module reg_bank
  import id_regfile_stage_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NREG     = NREG_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data_c,
  output logic [DATA_W-1:0] rt_data_c
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic              we_c;

  // Writes to a hardwired-zero register 0 are dropped.
  always_comb begin
    we_c  = wr_en && !(ZR && (wr_addr == '0));
    mem_d = mem_q;
    if (we_c) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Zero register overrides the bypass; otherwise the in-flight write wins.
  always_comb begin
    rs_data_c = mem_q[rs_addr];
    rt_data_c = mem_q[rt_addr];
    if (wr_en && (wr_addr == rs_addr)) rs_data_c = wr_data;
    if (wr_en && (wr_addr == rt_addr)) rt_data_c = wr_data;
    if (ZR && (rs_addr == '0)) rs_data_c = '0;
    if (ZR && (rt_addr == '0)) rt_data_c = '0;
  end

endmodule

// File: rtl/id_regfile_stage.sv
// Decode-stage register read: bypassed register bank feeding a stallable,
// flushable output stage whose held operands track in-flight writebacks.
module id_regfile_stage
  import id_regfile_stage_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NREG     = NREG_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [AW-1:0]     rs_addr_q,
  output logic [AW-1:0]     rt_addr_q
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] rs_rd_c, rt_rd_c;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [AW-1:0]     rs_addr_d, rt_addr_d;

  reg_bank #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data_c (rs_rd_c),
    .rt_data_c (rt_rd_c)
  );

  // Flush beats stall beats advance; a stalled operand follows writes to its register.
  always_comb begin
    out_valid_d = out_valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    if (flush) begin
      out_valid_d = 1'b0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
    end else if (stall) begin
      if (wr_en && (wr_addr == rs_addr_q))
        rs_data_d = (ZR && (rs_addr_q == '0)) ? '0 : wr_data;
      if (wr_en && (wr_addr == rt_addr_q))
        rt_data_d = (ZR && (rt_addr_q == '0)) ? '0 : wr_data;
    end else begin
      out_valid_d = in_valid;
      rs_data_d   = rs_rd_c;
      rt_data_d   = rt_rd_c;
      rs_addr_d   = rs_addr;
      rt_addr_d   = rt_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs_data   = rs_data_q;
  assign rt_data   = rt_data_q;

endmodule

// File: tb/tb_id_regfile_stage.sv
// Randomized self-checking bench for id_regfile_stage against a behavioural model.
module tb_id_regfile_stage;

  localparam int unsigned NR = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush, wr_en;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  rs_addr_q, rt_addr_q;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m [NR];
  logic        exp_v;
  logic [31:0] exp_rs, exp_rt;
  logic [4:0]  exp_ra, exp_rb;

  always #5 clk = ~clk;

  id_regfile_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .stall     (stall),
    .flush     (flush),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .rs_addr_q (rs_addr_q),
    .rt_addr_q (rt_addr_q)
  );

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m[i] = 32'h0;
    exp_v  = 1'b0;
    exp_rs = 32'h0;
    exp_rt = 32'h0;
    exp_ra = 5'h0;
    exp_rb = 5'h0;
  endtask

  // Architectural value a reader sees this cycle: r0 is zero, in-flight write wins.
  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  task automatic model_edge();
    logic [31:0] va, vb;
    va = rd_model(rs_addr);
    vb = rd_model(rt_addr);
    if (flush) begin
      exp_v = 1'b0; exp_rs = 32'h0; exp_rt = 32'h0; exp_ra = 5'h0; exp_rb = 5'h0;
    end else if (stall) begin
      if (wr_en && wr_addr == exp_ra) exp_rs = (exp_ra == 5'd0) ? 32'h0 : wr_data;
      if (wr_en && wr_addr == exp_rb) exp_rt = (exp_rb == 5'd0) ? 32'h0 : wr_data;
    end else begin
      exp_v = in_valid; exp_rs = va; exp_rt = vb; exp_ra = rs_addr; exp_rb = rt_addr;
    end
    if (wr_en && wr_addr != 5'd0) m[wr_addr] = wr_data;
  endtask

  task automatic check_all();
    check_eq("out_valid", 32'(out_valid), 32'(exp_v));
    check_eq("rs_data",   rs_data,        exp_rs);
    check_eq("rt_data",   rt_data,        exp_rt);
    check_eq("rs_addr_q", 32'(rs_addr_q), 32'(exp_ra));
    check_eq("rt_addr_q", 32'(rt_addr_q), 32'(exp_rb));
  endtask

  task automatic drive(input logic v, input logic s, input logic f,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid = v; stall = s; flush = f;
    rs_addr = ra; rt_addr = rb;
    wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later, return at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Reset pulse between edges: outputs must clear before the next clock edge.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_valid", 32'(out_valid), 32'h0);
    check_eq("async_rst_rs",    rs_data,        32'h0);
    check_eq("async_rst_rt",    rt_data,        32'h0);
    check_eq("async_rst_ra",    32'(rs_addr_q), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fresh registers read as zero with valid captured.
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r031_valid", 32'(out_valid), 32'h1);
    check_eq("r031_rs", rs_data, 32'h0);
    check_eq("r031_rt", rt_data, 32'h0);

    // Write-first bypass, then the value persists.
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_eq("r032_bypass", rs_data, 32'hDEADBEEF);
    check_eq("r032_rt_zero", rt_data, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r032_persist_rs", rs_data, 32'hDEADBEEF);
    check_eq("r032_persist_rt", rt_data, 32'hDEADBEEF);

    // r0 stays zero even while being written.
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234);
    tick();
    check_eq("r033_bypass_zero", rs_data, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r033_later_zero", rs_data, 32'h0);

    // Stalled operand refreshed by a write to its register.
    drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd8, 1'b1, 5'd7, 32'h11);
    tick();
    check_eq("r034_capture", rs_data, 32'h11);
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r034_hold1", rs_data, 32'h11);
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 32'h22);
    tick();
    check_eq("r034_refresh", rs_data, 32'h22);
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r034_hold3", rs_data, 32'h22);
    check_eq("r034_addr", 32'(rs_addr_q), 32'd7);
    check_eq("r034_valid", 32'(out_valid), 32'h1);

    // Flush beats stall; the write still lands.
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h55);
    tick();
    check_eq("r035_valid", 32'(out_valid), 32'h0);
    check_eq("r035_rs", rs_data, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r035_read", rs_data, 32'h55);

    // Reset mid-stall with a pending write discards everything.
    drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 32'h99);
    async_reset_pulse();
    drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r036_read", rs_data, 32'h0);

    // Random traffic over a few registers to exercise bypass/refresh overlaps.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_regfile_stage.md
ID_REGFILE_STAGE -- requirements
Module: id_regfile_stage

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter NREG, default 32, number of registers; SHALL be a power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1; 1 = register 0 reads as zero and ignores writes, 0 = register 0 is ordinary.
REQ-004 Derived AW = clog2(NREG), address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  decode slot carries a valid instruction.
REQ-008 stall  in  1  hold output stage.
REQ-009 flush  in  1  invalidate output stage.
REQ-010 rs_addr, rt_addr  in  AW each  read source addresses.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 wr_addr  in  AW  writeback destination.
REQ-013 wr_data  in  DATA_W  writeback value.
REQ-014 out_valid  out  1  registered valid.
REQ-015 rs_data, rt_data  out  DATA_W each  registered operands.
REQ-016 rs_addr_q, rt_addr_q  out  AW each  registered source addresses.

Function
REQ-017 Storage: NREG x DATA_W array; write at rising clk when wr_en=1, except wr_addr=0 with ZERO_REG=1 (write dropped).
REQ-018 Read path: combinational lookup of rs_addr/rt_addr with write-first bypass: wr_en=1 and wr_addr equal to the read address selects wr_data instead of the array.
REQ-019 Address 0 with ZERO_REG=1 returns 0, overriding bypass.
REQ-020 Output stage latency exactly 1 cycle: operands presented at edge N appear on outputs after edge N.
REQ-021 Per edge, priority flush > stall > advance.
REQ-022 flush=1: out_valid<=0, rs_data/rt_data/rs_addr_q/rt_addr_q<=0.
REQ-023 stall=1 (flush=0): out_valid and addresses held; held operand refreshed with wr_data when wr_en=1 and wr_addr equals rs_addr_q (resp. rt_addr_q), subject to REQ-019; otherwise held.
REQ-024 advance: out_valid<=in_valid; addresses and bypassed read data captured regardless of in_valid.
REQ-025 Same-address rs/rt both receive bypass/refresh identically.
REQ-026 Simultaneous stall and flush: flush wins; write to the array still occurs.

Reset
REQ-027 rst_n=0 asynchronously clears all array entries and all outputs to 0, out_valid=0, independent of clk.
REQ-028 Reset mid-stall or mid-write discards the pending write and the held state; first edge after release operates per REQ-021.

Structure
REQ-029 Shared package holds DATA_W/NREG defaults and a clog2 function; no other typedefs.
REQ-030 One sub-module reg_bank: array, write port, two bypassed read ports (REQ-017..019); id_regfile_stage adds the output stage and stall refresh.

Verification
REQ-031 Reset then read r5,r6 with in_valid=1 -> next cycle out_valid=1, rs_data=0, rt_data=0.
REQ-032 Write r5=0xDEADBEEF same cycle rs_addr=5 -> rs_data=0xDEADBEEF after that edge (bypass); later read r5 without write still 0xDEADBEEF.
REQ-033 ZERO_REG=1: write r0=0x1234 with rs_addr=0 -> rs_data=0 that cycle and all later reads.
REQ-034 Capture rs=7 (0x11), assert stall 3 cycles, write r7=0x22 in cycle 2 -> rs_data=0x22 from cycle 3, rs_addr_q=7, out_valid held 1.
REQ-035 stall=1 and flush=1 with wr r3=0x55 -> out_valid=0, outputs 0; subsequent read r3 returns 0x55.
REQ-036 rst_n low between clock edges during stall -> outputs 0 immediately; read r7 after release returns 0.
